// File: rtl/parity_monitor.sv
// parity_monitor
// Compares NCH pairs of parity bits from duplicated generators. Each channel has
// an enable and a consecutive-mismatch filter. The block keeps sticky errors, a
// saturating count of confirmed events, the first failing channel and an alarm.
// A req/ack handshake clears the sticky state.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_parity_a/b     parity bits from primary / checker generators
//   i_chk_en         per-channel check enable
//   i_inj_req        per-channel fault injection (forces a mismatch when enabled)
//   i_clr_req        level request to clear sticky state
//   o_clr_ack        one-cycle acknowledge of a clear
//   o_err_live       channel currently in confirmed mismatch
//   o_err_sticky     channel confirmed an error since the last clear
//   o_err_cnt        saturating count of confirmed events
//   o_first_valid    o_first_ch holds a captured channel
//   o_first_ch       lowest-index channel of the earliest confirm since clear
//   o_alarm          OR of the sticky bits
module parity_monitor #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned FILT  = 2,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   i_parity_a,
  input  logic [NCH-1:0]   i_parity_b,
  input  logic [NCH-1:0]   i_chk_en,
  input  logic [NCH-1:0]   i_inj_req,
  input  logic             i_clr_req,
  output logic             o_clr_ack,
  output logic [NCH-1:0]   o_err_live,
  output logic [NCH-1:0]   o_err_sticky,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_first_valid,
  output logic [CH_W-1:0]  o_first_ch,
  output logic             o_alarm
);

  localparam logic [3:0]       FiltVal = 4'(FILT);
  localparam logic [3:0]       FiltM1  = 4'(FILT - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StAck, StWait} clr_state_e;

  clr_state_e            r_state, w_state_d;
  logic [NCH-1:0][3:0]   r_fc, w_fc_d;
  logic [NCH-1:0]        r_sticky, w_sticky_d;
  logic [CNT_W-1:0]      r_cnt, w_cnt_d;
  logic                  r_first_valid, w_first_valid_d;
  logic [CH_W-1:0]       r_first_ch, w_first_ch_d;
  logic                  r_alarm, w_alarm_d;

  logic [NCH-1:0]        w_raw, w_conf, w_live;
  logic [5:0]            w_pop;
  logic [CH_W-1:0]       w_low;
  logic                  w_clr;
  logic [NCH-1:0]        w_sticky_base;
  logic [CNT_W-1:0]      w_cnt_base;
  logic                  w_fv_base;
  logic [CH_W-1:0]       w_fch_base;
  logic [CNT_W+5:0]      w_sum;

  assign w_raw = i_chk_en & (i_parity_a ^ i_parity_b ^ i_inj_req);

  // Filter: a confirm fires only on the cycle the run length reaches FILT, so a
  // long burst produces exactly one event.
  always_comb begin
    w_fc_d = r_fc;
    w_conf = '0;
    w_live = '0;
    w_pop  = '0;
    w_low  = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (!w_raw[i]) begin
        w_fc_d[i] = 4'd0;
      end else if (r_fc[i] != FiltVal) begin
        w_fc_d[i] = r_fc[i] + 4'd1;
      end
      w_conf[i] = w_raw[i] && (r_fc[i] == FiltM1);
      w_live[i] = (r_fc[i] == FiltVal);
      w_pop     = w_pop + 6'(w_conf[i]);
    end
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (w_conf[i]) w_low = CH_W'(i);
    end
  end

  // Clear handshake: only IDLE accepts a request, so a held request clears once.
  always_comb begin
    w_state_d = r_state;
    w_clr     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_clr_req) begin
          w_clr     = 1'b1;
          w_state_d = StAck;
        end
      end
      StAck:   w_state_d = i_clr_req ? StWait : StIdle;
      StWait:  if (!i_clr_req) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Same-cycle confirms land on top of the cleared state so no event is lost.
  always_comb begin
    w_sticky_base = w_clr ? '0 : r_sticky;
    w_cnt_base    = w_clr ? '0 : r_cnt;
    w_fv_base     = w_clr ? 1'b0 : r_first_valid;
    w_fch_base    = w_clr ? '0 : r_first_ch;

    w_sticky_d = w_sticky_base | w_conf;

    w_sum   = (CNT_W + 6)'(w_cnt_base) + (CNT_W + 6)'(w_pop);
    w_cnt_d = (w_sum > (CNT_W + 6)'(CntMax)) ? CntMax : w_sum[CNT_W-1:0];

    if (!w_fv_base && (|w_conf)) begin
      w_first_valid_d = 1'b1;
      w_first_ch_d    = w_low;
    end else begin
      w_first_valid_d = w_fv_base;
      w_first_ch_d    = w_fch_base;
    end

    w_alarm_d = |w_sticky_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_fc          <= '0;
      r_sticky      <= '0;
      r_cnt         <= '0;
      r_first_valid <= 1'b0;
      r_first_ch    <= '0;
      r_alarm       <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_fc          <= w_fc_d;
      r_sticky      <= w_sticky_d;
      r_cnt         <= w_cnt_d;
      r_first_valid <= w_first_valid_d;
      r_first_ch    <= w_first_ch_d;
      r_alarm       <= w_alarm_d;
    end
  end

  assign o_clr_ack     = (r_state == StAck);
  assign o_err_live    = w_live;
  assign o_err_sticky  = r_sticky;
  assign o_err_cnt     = r_cnt;
  assign o_first_valid = r_first_valid;
  assign o_first_ch    = r_first_ch;
  assign o_alarm       = r_alarm;

endmodule

// File: doc/parity_monitor.md
# parity_monitor

Multi-channel parity comparison and error-management unit. It is the parametrised successor of the single-pair parity comparator. It checks NCH independent parity pairs with per-channel enable, and suppresses glitches with a consecutive-mismatch filter. It latches sticky per-channel errors, counts confirmed error events, records the first failing channel, and supports fault injection for self-test and a req/ack clear handshake. It sits between the protected datapaths (duplicated parity generators) and the safety/interrupt controller.

## Interface
- NCH, 4: number of parity channels (1..32).
- FILT, 2: consecutive mismatching cycles required to confirm an error (1..15).
- CNT_W, 8: width of the confirmed-event counter (2..16).
- CH_W, max(1,clog2(NCH)): width of the channel index (derived, not overridden).

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- parity_a  in  NCH  parity bits from the primary generators.
- parity_b  in  NCH  parity bits from the checker generators.
- chk_en  in  NCH  per-channel check enable.
- inj_req  in  NCH  fault injection; forces a mismatch on channel i while high and chk_en[i]=1.
- clr_req  in  1  level request to clear the sticky state.
- clr_ack  out  1  one-cycle acknowledge of clr_req.
- err_live  out  NCH  channel currently in confirmed mismatch.
- err_sticky  out  NCH  channel has confirmed an error since the last clear.
- err_cnt  out  CNT_W  saturating count of confirmed events.
- first_valid  out  1  first_ch is valid.
- first_ch  out  CH_W  lowest-index channel of the earliest confirm since clear.
- alarm  out  1  OR of err_sticky.

## Operation
- Reset: all outputs are 0. Filter counters are 0. The clear FSM is in IDLE.
- Raw mismatch per channel: raw[i] = chk_en[i] & (parity_a[i] ^ parity_b[i] ^ inj_req[i]).
- Filter counter fc[i] is 4 bits:
  - if raw[i]=0, fc[i] goes to 0;
  - else fc[i] increments, saturating at FILT.
- Confirm event: conf[i] = raw[i] & (fc[i]==FILT-1). There is exactly one event per mismatch burst, however long the burst lasts.
- err_live[i] = (fc[i]==FILT). It drops on the first matching or disabled cycle.
- Sticky: err_sticky[i] is set on conf[i]. It is never cleared by chk_en=0. Only the clear handshake or reset clears it.
- Counter: err_cnt += popcount(conf), saturating at 2^CNT_W-1. It never wraps.
- First-channel capture: when first_valid=0 and any conf is set, first_ch gets the lowest set index and first_valid is set. Both then hold until the next clear.
- alarm = |err_sticky (next-state value, registered).
- Clear FSM, states IDLE, ACK, WAIT:
  - IDLE with clr_req=1: clear err_sticky, err_cnt and first_valid/first_ch, then go to ACK.
  - ACK: clr_ack=1. Go to WAIT if clr_req=1, else go to IDLE.
  - WAIT: go to IDLE when clr_req=0. A held clr_req therefore does not re-clear.
- Confirm in the same cycle as the clear: the events are applied on top of the cleared state. err_sticky equals conf, err_cnt equals popcount(conf), and first is captured from conf. No event is lost.
- Filter counters and err_live are not affected by clear.
- Reset asserted mid-burst or mid-handshake: everything returns to reset values immediately. The FSM goes to IDLE and clr_ack drops asynchronously.

## Timing
- Inputs are sampled on each rising edge. There is no combinational input-to-output path.
- Detection latency: a mismatch first sampled at edge k appears on err_live, err_sticky, err_cnt, first_ch and alarm after edge k+FILT-1. With FILT=1 this is the same edge.
- err_live deassert: one edge after the mismatch disappears.
- clr_req sampled high at edge t in IDLE:
  - cleared state is visible after edge t;
  - clr_ack is high for exactly the cycle between edges t and t+1.
- A new clear requires clr_req to be low for at least one edge after ACK or WAIT.
- A single-cycle inj_req pulse with FILT≥2 is filtered out: no sticky bit is set and the count does not change.

## Test plan
- Reset → all outputs 0. Then apply parity_a=4'b0101, parity_b=4'b0101, chk_en=4'hF for 20 cycles → no error, err_cnt=0.
- FILT=2: mismatch on ch2 for 1 cycle → nothing. Mismatch on ch2 for 5 cycles → err_live[2] high from the 2nd edge until 1 edge after the burst ends; err_sticky=4'b0100; err_cnt=1; first_ch=2; alarm=1.
- ch1 and ch3 confirm on the same edge, then ch0 confirms later → err_cnt=3, first_ch=1, err_sticky=4'b1011.
- CNT_W=2: 5 separate bursts on ch0 → err_cnt saturates at 3.
- Hold clr_req high 4 cycles → one clr_ack pulse; state cleared once. A ch2 confirm on the clear edge → err_sticky=4'b0100, err_cnt=1.
- inj_req[0] held 3 cycles with chk_en[0]=0 → no error. Repeat with chk_en[0]=1 → ch0 confirms. Assert rst_n=0 mid-burst → all outputs 0 immediately.
